eth_phy_10g_rx_lock_ctrl: RTL and testbench
===========================================

// Module: eth_phy_10g_rx_lock_ctrl
// PURPOSE
//  Clause-49-style block-lock controller for the 10G PCS RX path. Watches the 2-bit sync header
//  from the gearbox/aligner and drives a one-bit slip request to the barrel shifter until lock.
//  Also reports block lock, slip offset, high bit-error rate and an errored-header count.
//  Sits between the SERDES gearbox/aligner and the 64b/66b decoder; owns that shifter.
// PARAMETERS
//  HDR_WIDTH   2    sync header width; only 2 is supported
//  SLIP_WAIT   4    cycles headers are ignored after a slip pulse (shifter settle), 1..15
//  BER_WINDOW  1024 valid-header cycles per BER evaluation window, power of 2, >=64
//  BER_THRESH  16   invalid headers within one BER window that assert high BER, 1..255
// PORTS
//  clk            in   1          PCS RX clock
//  rst            in   1          asynchronous reset, active high
//  i_serdes_rx_hdr in  HDR_WIDTH  sync header of the current block
//  i_hdr_valid    in   1          header qualifier; the block ignores cycles with 0
//  o_bitslip      out  1          one-cycle request to shift the alignment by one bit
//  o_slip_offset  out  7          current shift, 0..65, mirrors shifter state
//  o_block_lock   out  1          block lock achieved
//  o_high_ber     out  1          BER window over threshold (only while locked)
//  o_err_count    out  8          invalid headers seen while locked, saturates at 255
// BEHAVIOUR
//  - Valid header = 2'b01 or 2'b10; 2'b00/2'b11 invalid. All counters count only i_hdr_valid cycles.
//  - Reset (async assert, sync release): state=TEST, all counters 0, every output 0.
//  - FSM states TEST, SLIP, WAIT, LOCKED:
//    TEST: sh_cnt counts headers 0..63. First invalid header -> SLIP (no lock).
//      64th consecutive valid header -> LOCKED, o_block_lock=1 the next cycle.
//    SLIP: o_bitslip=1 for exactly this one cycle. o_slip_offset wraps 65->0 the same edge.
//      Always goes to WAIT next. sh_cnt and inv_cnt are cleared.
//    WAIT: SLIP_WAIT clk cycles (valid or not). Headers are not evaluated. Then -> TEST.
//    LOCKED: 64-header windows. inv_cnt counts invalid headers in the window.
//      If inv_cnt reaches 16 (the 16th invalid header) -> SLIP; o_block_lock=0 the next cycle.
//      Otherwise sh_cnt and inv_cnt clear at the end of the window, after the 64th header is counted.
//      A header that is both the 64th and the 16th invalid one goes to SLIP; the 16th invalid wins.
//  - Latency: header evaluated on cycle N -> o_bitslip/o_block_lock changes on edge N+1.
//  - o_bitslip is never high on two consecutive cycles. Minimum spacing between pulses is
//    SLIP_WAIT+2 cycles.
//  - BER monitor runs only in LOCKED. It uses a log2(BER_WINDOW)-bit window counter and an
//    8-bit saturating bad-header counter.
//    o_high_ber is set the cycle after the bad-header count reaches BER_THRESH.
//    At window end: counters clear. o_high_ber clears if the just-ended window stayed below
//    BER_THRESH. A hit on the last header of the window still sets o_high_ber.
//    Leaving LOCKED: o_high_ber=0 and the BER counters clear.
//  - o_err_count increments on each invalid header in LOCKED, saturates at 255, clears only by rst.
//  - i_hdr_valid=0 freezes the TEST/LOCKED counters but does not pause the WAIT countdown.
//  - Reset mid-slip or mid-wait: immediate return to reset state. o_slip_offset=0, which
//    requires the shifter to share the same rst.
// TESTING
//  1 Always 2'b01 from reset -> o_bitslip never pulses. o_block_lock=1 on the edge after the 64th header.
//  2 2'b11 for 3 blocks, then valid -> three o_bitslip pulses each SLIP_WAIT+2 cycles apart,
//    o_slip_offset=3, then lock after 64 valid headers.
//  3 Locked, then 15 invalid in one 64-window -> stays locked. Same for the next window.
//    16th invalid in a window -> o_bitslip=1 and o_block_lock=0 on the next edge.
//  4 Locked, BER_THRESH=16, 16 invalid spread across 4 64-windows of one BER window -> lock held,
//    o_high_ber=1. Next BER window clean -> o_high_ber=0 at its end. o_err_count=16.
//  5 68 slips from offset 0 -> o_slip_offset wraps 65->0 and then reads 2.
//    i_hdr_valid=0 gaps do not advance sh_cnt.
//  6 Assert rst during WAIT and during LOCKED -> all outputs 0 immediately, without a clock edge.
//    After release, the lock sequence restarts from TEST.

Source files
------------

// File: rtl/eth_phy_10g_rx_lock_ctrl.sv
// Block-lock controller for the 10G PCS RX path: hunts for 64b/66b sync-header
// alignment by slipping the barrel shifter, then monitors lock quality and BER.
module eth_phy_10g_rx_lock_ctrl #(
    parameter int HDR_WIDTH  = 2,
    parameter int SLIP_WAIT  = 4,
    parameter int BER_WINDOW = 1024,
    parameter int BER_THRESH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HDR_WIDTH-1:0] i_serdes_rx_hdr,
    input  logic                 i_hdr_valid,
    output logic                 o_bitslip,
    output logic [6:0]           o_slip_offset,
    output logic                 o_block_lock,
    output logic                 o_high_ber,
    output logic [7:0]           o_err_count
);

    localparam int SH_WINDOW  = 64;
    localparam int LOCK_INV   = 16;
    localparam int MAX_OFFSET = 65;
    localparam int WAIT_W     = 4;
    localparam int BER_CNT_W  = $clog2(BER_WINDOW);

    typedef enum logic [1:0] {
        ST_TEST   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           sh_cnt_q, sh_cnt_d;
    logic [4:0]           inv_cnt_q, inv_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [6:0]           offset_q, offset_d;
    logic [BER_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]           bad_cnt_q, bad_cnt_d;
    logic                 high_ber_q, high_ber_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic       hdr_good;
    logic       hdr_bad;
    logic       ber_active;
    logic [7:0] bad_sat;
    logic [7:0] bad_next;
    logic       ber_hit;

    // A legal sync header has exactly one bit set (01 or 10).
    assign hdr_good = ^i_serdes_rx_hdr;
    assign hdr_bad  = i_hdr_valid && !hdr_good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_TEST;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            offset_q   <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            high_ber_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            offset_q   <= offset_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            high_ber_q <= high_ber_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_TEST: begin
                if (i_hdr_valid) begin
                    if (!hdr_good) begin
                        state_d = ST_SLIP;
                    end else if (sh_cnt_q == 6'(SH_WINDOW - 1)) begin
                        state_d   = ST_LOCKED;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 6'd1;
                    end
                end
            end
            ST_SLIP: begin
                state_d    = ST_WAIT;
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                // Settle time runs on every clock, qualified header or not.
                if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d = ST_TEST;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (i_hdr_valid) begin
                    // The 16th bad header beats the end-of-window clear.
                    if (!hdr_good && inv_cnt_q == 5'(LOCK_INV - 1)) begin
                        state_d = ST_SLIP;
                    end else if (sh_cnt_q == 6'(SH_WINDOW - 1)) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 6'd1;
                        if (!hdr_good) begin
                            inv_cnt_d = inv_cnt_q + 5'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_TEST;
            end
        endcase
    end

    // Shadow of the barrel shifter position; it moves when the pulse is consumed.
    always_comb begin
        offset_d = offset_q;
        if (state_q == ST_SLIP) begin
            offset_d = (offset_q == 7'(MAX_OFFSET)) ? 7'd0 : offset_q + 7'd1;
        end
    end

    assign ber_active = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    assign bad_sat    = (bad_cnt_q == 8'hFF) ? bad_cnt_q : bad_cnt_q + 8'd1;
    assign bad_next   = hdr_bad ? bad_sat : bad_cnt_q;
    assign ber_hit    = (bad_next >= 8'(BER_THRESH));

    always_comb begin
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        high_ber_d = high_ber_q;
        if (!ber_active) begin
            win_cnt_d  = '0;
            bad_cnt_d  = '0;
            high_ber_d = 1'b0;
        end else if (i_hdr_valid) begin
            if (win_cnt_q == BER_CNT_W'(BER_WINDOW - 1)) begin
                // Flag for the next window reflects only the window just closed.
                win_cnt_d  = '0;
                bad_cnt_d  = '0;
                high_ber_d = ber_hit;
            end else begin
                win_cnt_d  = win_cnt_q + 1'b1;
                bad_cnt_d  = bad_next;
                high_ber_d = high_ber_q || ber_hit;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == ST_LOCKED && hdr_bad && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign o_bitslip     = (state_q == ST_SLIP);
    assign o_block_lock  = (state_q == ST_LOCKED);
    assign o_slip_offset = offset_q;
    assign o_high_ber    = high_ber_q;
    assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_ctrl.sv
// Directed bench for eth_phy_10g_rx_lock_ctrl: lock hunt, slips, loss of lock,
// BER flag, offset wrap, qualifier gaps and asynchronous reset.
module tb_eth_phy_10g_rx_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] hdr = 2'b00;
    logic       vld = 1'b0;

    logic       bitslip;
    logic [6:0] offset;
    logic       block_lock;
    logic       high_ber;
    logic [7:0] err_count;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    eth_phy_10g_rx_lock_ctrl #(
        .HDR_WIDTH  (2),
        .SLIP_WAIT  (4),
        .BER_WINDOW (1024),
        .BER_THRESH (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_serdes_rx_hdr (hdr),
        .i_hdr_valid     (vld),
        .o_bitslip       (bitslip),
        .o_slip_offset   (offset),
        .o_block_lock    (block_lock),
        .o_high_ber      (high_ber),
        .o_err_count     (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping sampled on the falling edge, away from the active edge.
    int pulses     = 0;
    int last_pulse = 0;
    int last_gap   = 0;
    always @(negedge clk) begin
        if (bitslip) begin
            pulses     <= pulses + 1;
            last_gap   <= cyc - last_pulse;
            last_pulse <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] h, input logic v);
        hdr = h;
        vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int p0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_bitslip", bitslip, 0);
        check("rst_lock", block_lock, 0);
        check("rst_offset", offset, 0);
        check("rst_high_ber", high_ber, 0);
        check("rst_err", err_count, 0);
        rst = 1'b0;

        // 1: clean headers lock on the 64th
        repeat (63) drive(2'b01, 1'b1);
        check("t1_lock_after63", block_lock, 0);
        drive(2'b01, 1'b1);
        check("t1_lock_after64", block_lock, 1);
        check("t1_no_pulses", pulses, 0);
        check("t1_offset", offset, 0);

        // 2: three bad headers -> three slips, headers ignored during SLIP/WAIT
        do_reset();
        p0 = pulses;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b1);
            check("t2_pulse_high", bitslip, 1);
            drive(2'b00, 1'b1);
            check("t2_pulse_single", bitslip, 0);
            repeat (4) drive(2'b00, 1'b1);
        end
        check("t2_pulse_count", pulses - p0, 3);
        check("t2_pulse_gap", last_gap, 6);
        check("t2_offset", offset, 3);
        repeat (63) drive(2'b01, 1'b1);
        check("t2_lock_after63", block_lock, 0);
        drive(2'b01, 1'b1);
        check("t2_lock_after64", block_lock, 1);

        // 3: 15 bad per 64-window keeps lock; the 16th drops it
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 64; i++) drive((i < 15) ? 2'b00 : 2'b01, 1'b1);
            check("t3_lock_15bad", block_lock, 1);
        end
        check("t3_high_ber", high_ber, 1);
        check("t3_err_30", err_count, 30);
        repeat (15) drive(2'b11, 1'b1);
        check("t3_lock_w3_15bad", block_lock, 1);
        check("t3_no_slip_yet", bitslip, 0);
        drive(2'b11, 1'b1);
        check("t3_slip_on_16th", bitslip, 1);
        check("t3_lock_lost", block_lock, 0);
        check("t3_ber_cleared", high_ber, 0);
        check("t3_err_46", err_count, 46);

        // 4: 16 bad spread over 4 windows of one BER window
        do_reset();
        repeat (64) drive(2'b01, 1'b1);
        check("t4_locked", block_lock, 1);
        for (int w = 0; w < 3; w++) begin
            repeat (4) drive(2'b00, 1'b1);
            repeat (60) drive(2'b01, 1'b1);
        end
        repeat (3) drive(2'b00, 1'b1);
        check("t4_ber_below", high_ber, 0);
        drive(2'b00, 1'b1);
        check("t4_ber_set", high_ber, 1);
        repeat (60) drive(2'b01, 1'b1);
        check("t4_lock_held", block_lock, 1);
        repeat (767) drive(2'b01, 1'b1);
        check("t4_ber_win1_last", high_ber, 1);
        drive(2'b01, 1'b1);
        check("t4_ber_win1_end", high_ber, 1);
        repeat (1023) drive(2'b10, 1'b1);
        check("t4_ber_win2_pre", high_ber, 1);
        drive(2'b10, 1'b1);
        check("t4_ber_win2_end", high_ber, 0);
        check("t4_err_16", err_count, 16);
        check("t4_lock_end", block_lock, 1);

        // 5: offset wrap over 68 slips, valid gaps do not count
        do_reset();
        p0 = pulses;
        for (int s = 1; s <= 68; s++) begin
            drive(2'b11, 1'b1);
            repeat (5) drive(2'b00, 1'b1);
            if (s == 65) check("t5_offset_65", offset, 65);
            if (s == 66) check("t5_offset_wrap", offset, 0);
        end
        check("t5_offset_2", offset, 2);
        check("t5_pulses_68", pulses - p0, 68);
        for (int i = 0; i < 63; i++) begin
            drive(2'b01, 1'b1);
            drive(2'b00, 1'b0);
        end
        check("t5_gap_lock63", block_lock, 0);
        drive(2'b01, 1'b1);
        check("t5_gap_lock64", block_lock, 1);

        // 6: async reset while LOCKED and while in WAIT
        repeat (3) drive(2'b00, 1'b1);
        check("t6_err_3", err_count, 3);
        #2 rst = 1'b1;
        #1;
        check("t6_lk_rst_lock", block_lock, 0);
        check("t6_lk_rst_offset", offset, 0);
        check("t6_lk_rst_err", err_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b11, 1'b1);
        check("t6_slip", bitslip, 1);
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b1);
        check("t6_wait_offset", offset, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_wt_rst_offset", offset, 0);
        check("t6_wt_rst_slip", bitslip, 0);
        check("t6_wt_rst_lock", block_lock, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (63) drive(2'b01, 1'b1);
        check("t6_relock_63", block_lock, 0);
        drive(2'b01, 1'b1);
        check("t6_relock_64", block_lock, 1);
        check("t6_relock_offset", offset, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
